// File: rtl/seven_seg_scan.sv
// seven_seg_scan: drives the Nexys A7 8-digit common-anode display from eight character words.
// Takes one snapshot of all words per frame, blanks at each digit change, and registers every output.
// Optional whole-display flashing is built only when SEVEN_SEG_BLINK_EN is defined.
module seven_seg_scan #(
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLANK_CYC    = 1000,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [6:0] d1,
  input  logic [6:0] d2,
  input  logic [6:0] d3,
  input  logic [6:0] d4,
  input  logic [6:0] d5,
  input  logic [6:0] d6,
  input  logic [6:0] d7,
  input  logic [6:0] d8,
  input  logic       blink,
  output logic [7:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_start
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_idx;
  logic [7:0][6:0]  r_shadow;

  logic [7:0][6:0]  w_words;
  logic [6:0]       w_cur;
  logic             w_cnt_last;
  logic             w_frame_end;
  logic             w_snap;
  logic             w_gap;
  logic             w_blink_off;

  assign w_words     = {d8, d7, d6, d5, d4, d3, d2, d1};
  assign w_cur       = r_shadow[r_idx];
  assign w_cnt_last  = (r_cnt == CNT_LAST);
  assign w_frame_end = w_cnt_last && (r_idx == 3'd7);
  assign w_snap      = (r_cnt == '0) && (r_idx == 3'd0);
  assign w_gap       = (32'(r_cnt) < BLANK_CYC);

  // Character code to active-low {g,f,e,d,c,b,a}; anything unlisted is dark.
  function automatic logic [6:0] f_decode(input logic [4:0] code);
    logic [6:0] s;
    case (code)
      5'h00:   s = 7'h40;
      5'h01:   s = 7'h79;
      5'h02:   s = 7'h24;
      5'h03:   s = 7'h30;
      5'h04:   s = 7'h19;
      5'h05:   s = 7'h61;
      5'h06:   s = 7'h12;
      5'h07:   s = 7'h06;
      5'h08:   s = 7'h07;
      5'h09:   s = 7'h41;
      5'h0A:   s = 7'h0C;
      5'h0B:   s = 7'h03;
      5'h0C:   s = 7'h46;
      5'h0D:   s = 7'h47;
      5'h0E:   s = 7'h11;
      5'h0F:   s = 7'h42;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

`ifdef SEVEN_SEG_BLINK_EN
  localparam int unsigned FR_W = (BLINK_FRAMES > 2) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FR_W-1:0] FR_LAST = FR_W'(BLINK_FRAMES - 1);

  logic [FR_W-1:0] r_frame_cnt;
  logic            r_blink_phase;

  // Frame counter: flips the blink phase every BLINK_FRAMES completed frames.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_frame_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (w_frame_end) begin
      if (r_frame_cnt == FR_LAST) begin
        r_frame_cnt   <= '0;
        r_blink_phase <= ~r_blink_phase;
      end else begin
        r_frame_cnt <= r_frame_cnt + 1'b1;
      end
    end
  end

  assign w_blink_off = blink & r_blink_phase;
`else
  logic w_unused_blink;
  assign w_unused_blink = blink ^ (BLINK_FRAMES == 0);
  assign w_blink_off    = 1'b0;
`endif

  // Slot timer and digit index; the index advances when the slot timer wraps.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt <= '0;
      r_idx <= 3'd0;
    end else if (w_cnt_last) begin
      r_cnt <= '0;
      r_idx <= r_idx + 3'd1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Frame snapshot of all eight words, with a one-cycle marker afterwards.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_shadow    <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= w_snap;
      if (w_snap) begin
        r_shadow <= w_words;
      end
    end
  end

  // Registered display drive: dark in the gap or blink-off phase, else the selected digit.
  always_ff @(posedge clock) begin
    if (reset || w_gap || w_blink_off) begin
      an  <= 8'hFF;
      seg <= 7'h7F;
      dp  <= 1'b1;
    end else begin
      an  <= ~(8'h01 << r_idx);
      seg <= w_cur[6] ? f_decode(w_cur[5:1]) : 7'h7F;
      dp  <= w_cur[0] | ~w_cur[6];
    end
  end

endmodule

// File: tb/tb_seven_seg_scan.sv
// tb_seven_seg_scan: scoreboard bench for seven_seg_scan with a cycle-count reference model.
module tb_seven_seg_scan;

  localparam int unsigned R  = 4;
  localparam int unsigned B  = 1;
  localparam int unsigned BF = 2;
  localparam int unsigned FRAME = 8 * R;
`ifdef SEVEN_SEG_BLINK_EN
  localparam bit BLINK_ON = 1'b1;
`else
  localparam bit BLINK_ON = 1'b0;
`endif

  localparam logic [6:0] SEG_TAB [17] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h61, 7'h12,
                                          7'h06, 7'h07, 7'h41, 7'h0C, 7'h03, 7'h46, 7'h47,
                                          7'h11, 7'h42, 7'h7F};

  typedef struct packed {
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fs;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       blink;
  logic [6:0] d [8];
  logic [7:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame_start;

  int   checks   = 0;
  int   failures = 0;
  obs_t q [$];
  int unsigned t = 0;
  logic [6:0] m_shadow [8];
  bit started = 1'b0;

  seven_seg_scan #(.REFRESH_DIV(R), .BLANK_CYC(B), .BLINK_FRAMES(BF)) dut (
    .clock(clk), .reset(rst),
    .d1(d[0]), .d2(d[1]), .d3(d[2]), .d4(d[3]),
    .d5(d[4]), .d6(d[5]), .d7(d[6]), .d8(d[7]),
    .blink(blink), .an(an), .seg(seg), .dp(dp), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input logic [4:0] code);
    return (code < 5'd16) ? SEG_TAB[code] : 7'h7F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  // Reference model: t counts cycles since reset release; slot, gap and frame follow by division.
  always @(posedge clk) begin
    obs_t e;
    int unsigned slot, pos, frame;
    logic [6:0] w;
    logic dark;
    started = 1'b1;
    if (rst) begin
      e = '{an: 8'hFF, seg: 7'h7F, dp: 1'b1, fs: 1'b0};
      t = 0;
      for (int i = 0; i < 8; i++) m_shadow[i] = 7'h00;
    end else begin
      slot  = (t / R) % 8;
      pos   = t % R;
      frame = t / FRAME;
      dark  = (pos < B) || (BLINK_ON && blink && ((frame / BF) % 2 == 1));
      w     = m_shadow[slot];
      if (dark) begin
        e.an = 8'hFF; e.seg = 7'h7F; e.dp = 1'b1;
      end else begin
        e.an  = 8'(8'hFF - (1 << slot));
        e.seg = w[6] ? seg_of(w[5:1]) : 7'h7F;
        e.dp  = !(w[6] && !w[0]);
      end
      e.fs = ((t % FRAME) == 0);
      if (e.fs) for (int i = 0; i < 8; i++) m_shadow[i] = d[i];
      t++;
    end
    q.push_back(e);
  end

  // Monitor: every cycle the DUT presents a new output word; compare it to the queued prediction.
  always @(negedge clk) begin
    obs_t e, a;
    if (started) begin
      a = '{an: an, seg: seg, dp: dp, fs: frame_start};
      if (q.size() == 0) begin
        chk("scoreboard_empty", 32'(a), 32'hFFFF_FFFF);
      end else begin
        e = q.pop_front();
        chk("scoreboard", 32'(a), 32'(e));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Advance until the design is in the given in-frame cycle.
  task automatic wait_state(input int unsigned ph);
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (!rst && (t % FRAME) == ph) return;
      cyc(1);
    end
    chk("wait_state_timeout", 32'(ph), 32'hFFFF_FFFF);
  endtask

  task automatic wait_fs();
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      if (frame_start === 1'b1) return;
    end
    chk("wait_fs_timeout", 32'd0, 32'd1);
  endtask

  // Find the next lit cycle of a digit and check its segments and point against constants.
  task automatic expect_slot(input int s, input logic [6:0] sg, input logic dpv);
    logic [7:0] tgt;
    tgt = 8'hFF;
    tgt[s] = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      if (an === tgt) begin
        chk($sformatf("slot%0d_seg", s), 32'(seg), 32'(sg));
        chk($sformatf("slot%0d_dp", s), 32'(dp), 32'(dpv));
        return;
      end
    end
    chk($sformatf("slot%0d_timeout", s), 32'(an), 32'(tgt));
  endtask

  function automatic logic [6:0] rand_word();
    logic [6:0] w;
    w[6]   = ($urandom_range(0, 7) != 0);
    w[5:1] = 5'($urandom_range(0, 20));
    w[0]   = 1'($urandom);
    return w;
  endfunction

  initial begin
    logic [6:0] setup [8];
    setup = '{7'h55, 7'h53, 7'h51, 7'h4F, 7'h4D, 7'h61, 7'h43, 7'h4B};
    rst = 1'b1;
    blink = 1'b0;
    for (int i = 0; i < 8; i++) d[i] = setup[i];
    cyc(3);
    rst = 1'b0;

    // Release timing: marker in the second cycle, first digit lit in the third.
    @(negedge clk);
    chk("rel_c1_fs", 32'(frame_start), 32'd0);
    chk("rel_c1_an", 32'(an), 32'hFF);
    @(negedge clk);
    chk("rel_c2_fs", 32'(frame_start), 32'd1);
    chk("rel_c2_an", 32'(an), 32'hFF);
    @(negedge clk);
    chk("rel_c3_an", 32'(an), 32'hFE);
    chk("rel_c3_seg", 32'(seg), 32'h0C);

    // Fixed message across the eight digits.
    expect_slot(1, 7'h41, 1'b1);
    expect_slot(2, 7'h07, 1'b1);
    expect_slot(3, 7'h06, 1'b1);
    expect_slot(4, 7'h12, 1'b1);
    expect_slot(5, 7'h7F, 1'b1);
    expect_slot(6, 7'h79, 1'b1);
    expect_slot(7, 7'h61, 1'b1);

    // Mid-frame input change becomes visible only from the next snapshot.
    wait_state(3 * R);
    d[0] = 7'h47;
    wait_fs();
    expect_slot(0, 7'h30, 1'b1);

    // Dark digit, decimal point on, out-of-table code.
    d[2] = 7'h00;
    d[3] = 7'h48;
    d[4] = 7'h66;
    wait_fs();
    expect_slot(2, 7'h7F, 1'b1);
    expect_slot(3, 7'h19, 1'b0);
    expect_slot(4, 7'h7F, 1'b0);

    // Reset in the middle of slot 5.
    wait_state(5 * R + 2);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midreset_an", 32'(an), 32'hFF);
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) d[i] = rand_word();
    rst = 1'b0;
    cyc(2 * FRAME);

    // Randomised words, changing at arbitrary cycles, with random blink requests.
    for (int c = 0; c < 10 * FRAME; c++) begin
      if ($urandom_range(0, 5) == 0) d[$urandom_range(0, 7)] = rand_word();
      if ($urandom_range(0, 40) == 0) blink = ~blink;
      cyc(1);
    end

    // Realign frames with a reset, then hold blink through six frames.
    blink = 1'b1;
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(6 * FRAME + 4);
    blink = 1'b0;
    cyc(R + 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
